// File: rtl/game_sequencer.sv
// Purpose : frame-synchronous master scheduler for the obstacle/player game (states, step pulses, level).
// Latency : all outputs registered; a step pulse appears 1 cycle after its qualifying iFrameTick.
// Backpress: none; inputs are levels/pulses sampled every cycle, outputs are single-cycle enables.
// Ports   : iClk/iReset (sync, active-low); iFrameTick, iStart, iPause, iStop, iPunto in;
//           oStepCarros/oStepJugador step pulses, oEnableLFSR, oPintar, oResetPintar,
//           oNivel (level), oCuenta (countdown digit), oEstado (state code).
// Config  : define SEQ_PAUSA_EN to build the PAUSA state and the pause-button edge detector.
module game_sequencer #(
  parameter int FRAMES_INICIAL = 30,
  parameter int PASO_NIVEL     = 4,
  parameter int FRAMES_MIN     = 6,
  parameter int PUNTOS_NIVEL   = 5,
  parameter int NIVEL_MAX      = 7,
  parameter int CUENTA_FRAMES  = 60,
  parameter int CHOQUE_FRAMES  = 90
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iFrameTick,
  input  logic       iStart,
  input  logic       iPause,
  input  logic       iStop,
  input  logic       iPunto,
  output logic       oStepCarros,
  output logic       oStepJugador,
  output logic       oEnableLFSR,
  output logic       oPintar,
  output logic       oResetPintar,
  output logic [2:0] oNivel,
  output logic [1:0] oCuenta,
  output logic [2:0] oEstado
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CUENTA = 3'd1,
    JUEGO  = 3'd2,
    PAUSA  = 3'd3,
    CHOQUE = 3'd4,
    FIN    = 3'd5
  } estadoT;

  localparam logic signed [8:0] INI_S      = 9'(FRAMES_INICIAL);
  localparam logic signed [8:0] PASO_S     = 9'(PASO_NIVEL);
  localparam logic signed [8:0] MIN_S      = 9'(FRAMES_MIN);
  localparam logic [7:0]        CUENTA_LIM = 8'(CUENTA_FRAMES - 1);
  localparam logic [7:0]        CHOQUE_LIM = 8'(CHOQUE_FRAMES - 1);
  localparam logic [7:0]        PUNTOS_LIM = 8'(PUNTOS_NIVEL - 1);
  localparam logic [2:0]        NIVEL_TOP  = 3'(NIVEL_MAX);

  estadoT      estado;
  logic [7:0]  frameCnt;
  logic [7:0]  cntInc;
  logic [7:0]  puntosCnt;
  logic [7:0]  puntosSig;
  logic [2:0]  nivelSig;
  logic        startPrev;
  logic        startEdge;
  logic        pauseEdge;
  logic signed [8:0] periodoRaw;
  logic [7:0]  pLimite;

  assign oEstado   = estado;
  assign startEdge = iStart & ~startPrev;
  assign cntInc    = frameCnt + 8'd1;

`ifdef SEQ_PAUSA_EN
  logic pausePrev;
  always_ff @(posedge iClk) begin
    if (!iReset) pausePrev <= 1'b0;
    else         pausePrev <= iPause;
  end
  assign pauseEdge = iPause & ~pausePrev;
`else
  logic unusedPausa;
  assign unusedPausa = iPause;
  assign pauseEdge   = 1'b0;
`endif

  // Step period in signed 9 bits so a large level*step cannot wrap below the floor.
  // pLimite is the counter value (P-1) at which a tick produces an obstacle step.
  always_comb begin
    periodoRaw = INI_S - $signed({6'd0, oNivel}) * PASO_S;
    if (periodoRaw < MIN_S) pLimite = 8'(FRAMES_MIN - 1);
    else                    pLimite = periodoRaw[7:0] - 8'd1;
  end

  // Point accumulation; the point counter clears every PUNTOS_NIVEL points even at max level.
  always_comb begin
    puntosSig = puntosCnt;
    nivelSig  = oNivel;
    if (iPunto) begin
      if (puntosCnt == PUNTOS_LIM) begin
        puntosSig = 8'd0;
        if (oNivel < NIVEL_TOP) nivelSig = oNivel + 3'd1;
      end else begin
        puntosSig = puntosCnt + 8'd1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iReset) begin
      estado       <= IDLE;
      frameCnt     <= 8'd0;
      puntosCnt    <= 8'd0;
      startPrev    <= 1'b0;
      oNivel       <= 3'd0;
      oCuenta      <= 2'd0;
      oStepCarros  <= 1'b0;
      oStepJugador <= 1'b0;
      oEnableLFSR  <= 1'b0;
      oPintar      <= 1'b0;
      oResetPintar <= 1'b1;
    end else begin
      startPrev    <= iStart;
      oStepCarros  <= 1'b0;
      oStepJugador <= 1'b0;
      oResetPintar <= 1'b0;
      case (estado)
        IDLE: begin
          oResetPintar <= 1'b1;
          oPintar      <= 1'b0;
          oNivel       <= 3'd0;
          oCuenta      <= 2'd0;
          oEnableLFSR  <= 1'b0;
          frameCnt     <= 8'd0;
          puntosCnt    <= 8'd0;
          if (startEdge) begin
            estado      <= CUENTA;
            oCuenta     <= 2'd3;
            oPintar     <= 1'b1;
            oEnableLFSR <= 1'b1;
          end
        end
        CUENTA: begin
          oEnableLFSR <= 1'b1;
          oPintar     <= 1'b1;
          if (iFrameTick) begin
            if (frameCnt == CUENTA_LIM) begin
              frameCnt <= 8'd0;
              oCuenta  <= oCuenta - 2'd1;
              if (oCuenta == 2'd1) estado <= JUEGO;
            end else begin
              frameCnt <= cntInc;
            end
          end
        end
        JUEGO: begin
          // Points are taken in every JUEGO cycle, including the one that leaves it.
          puntosCnt   <= puntosSig;
          oNivel      <= nivelSig;
          oEnableLFSR <= 1'b1;
          oPintar     <= 1'b1;
          if (iStop) begin
            estado      <= CHOQUE;
            frameCnt    <= 8'd0;
            oEnableLFSR <= 1'b0;
          end
`ifdef SEQ_PAUSA_EN
          else if (pauseEdge) begin
            estado      <= PAUSA;
            oEnableLFSR <= 1'b0;
          end
`endif
          else if (iFrameTick) begin
            oStepJugador <= 1'b1;
            // >= rather than == so a level-up that shrinks P below the count steps on the next tick.
            if (frameCnt >= pLimite) begin
              oStepCarros <= 1'b1;
              frameCnt    <= 8'd0;
            end else begin
              frameCnt <= cntInc;
            end
          end
        end
`ifdef SEQ_PAUSA_EN
        PAUSA: begin
          oPintar <= 1'b1;
          if (pauseEdge) begin
            estado      <= JUEGO;
            oEnableLFSR <= 1'b1;
          end
        end
`endif
        CHOQUE: begin
          oEnableLFSR <= 1'b0;
          if (iFrameTick) begin
            if (frameCnt == CHOQUE_LIM) begin
              estado  <= FIN;
              oPintar <= 1'b1;
            end else begin
              frameCnt <= cntInc;
              oPintar  <= ~cntInc[3];
            end
          end
        end
        FIN: begin
          oPintar     <= 1'b1;
          oEnableLFSR <= 1'b0;
          if (startEdge) begin
            estado       <= CUENTA;
            oCuenta      <= 2'd3;
            oNivel       <= 3'd0;
            puntosCnt    <= 8'd0;
            frameCnt     <= 8'd0;
            oResetPintar <= 1'b1;
            oEnableLFSR  <= 1'b1;
          end
        end
        default: begin
          estado       <= IDLE;
          oResetPintar <= 1'b1;
          oPintar      <= 1'b0;
          oNivel       <= 3'd0;
          oCuenta      <= 2'd0;
          oEnableLFSR  <= 1'b0;
          frameCnt     <= 8'd0;
          puntosCnt    <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Purpose : directed bench for game_sequencer with a step-pulse scoreboard.
// Latency : expects every step pulse exactly one cycle after its frame tick.
// Backpress: n/a; stimulus pushes expected pulses, a negedge monitor pops and compares.
module tb_game_sequencer;

  logic       iClk = 1'b0;
  logic       iReset = 1'b0;
  logic       iFrameTick = 1'b0;
  logic       iStart = 1'b0;
  logic       iPause = 1'b0;
  logic       iStop = 1'b0;
  logic       iPunto = 1'b0;
  logic       oStepCarros, oStepJugador, oEnableLFSR, oPintar, oResetPintar;
  logic [2:0] oNivel;
  logic [1:0] oCuenta;
  logic [2:0] oEstado;

  game_sequencer dut (
    .iClk(iClk), .iReset(iReset), .iFrameTick(iFrameTick), .iStart(iStart),
    .iPause(iPause), .iStop(iStop), .iPunto(iPunto),
    .oStepCarros(oStepCarros), .oStepJugador(oStepJugador), .oEnableLFSR(oEnableLFSR),
    .oPintar(oPintar), .oResetPintar(oResetPintar), .oNivel(oNivel),
    .oCuenta(oCuenta), .oEstado(oEstado)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit carros;
    bit jug;
  } expT;

  expT q[$];
  int  nCmp = 0;
  int  nBad = 0;
  bit  monOn = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nBad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushExp(input bit c, input bit j);
    expT e;
    e.cyc    = cyc + 1;
    e.carros = c;
    e.jug    = j;
    q.push_back(e);
  endtask

  // One frame tick (high one cycle, low one cycle) with the step pulses it should produce.
  task automatic tick(input bit c, input bit j);
    @(negedge iClk);
    iFrameTick = 1'b1;
    pushExp(c, j);
    @(negedge iClk);
    iFrameTick = 1'b0;
  endtask

  task automatic punto();
    @(negedge iClk);
    iPunto = 1'b1;
    @(negedge iClk);
    iPunto = 1'b0;
  endtask

  // Monitor: every cycle that carries an expectation is compared; any pulse elsewhere is an error.
  always @(negedge iClk) begin : monitor
    expT e;
    if (monOn) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        nCmp++;
        nBad++;
        $display("FAIL step_missed: expectation for cycle %0d never checked", e.cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        nCmp++;
        if (oStepCarros !== e.carros || oStepJugador !== e.jug) begin
          nBad++;
          $display("FAIL step_pulse: cycle %0d got carros=%b jugador=%b, expected carros=%b jugador=%b",
                   cyc, oStepCarros, oStepJugador, e.carros, e.jug);
        end
      end else if (oStepCarros || oStepJugador) begin
        nCmp++;
        nBad++;
        $display("FAIL step_unexpected: cycle %0d got carros=%b jugador=%b, expected none",
                 cyc, oStepCarros, oStepJugador);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset and countdown
    repeat (2) @(negedge iClk);
    iReset = 1'b1;
    monOn  = 1'b1;
    check("rst_estado", oEstado, 0);
    check("rst_resetPintar", oResetPintar, 1);
    check("rst_pintar", oPintar, 0);
    check("rst_lfsr", oEnableLFSR, 0);
    check("rst_nivel", oNivel, 0);
    check("rst_cuenta", oCuenta, 0);
    @(negedge iClk);
    check("idle_estado", oEstado, 0);
    iStart = 1'b1;
    @(negedge iClk);
    check("start_estado", oEstado, 1);
    check("start_cuenta", oCuenta, 3);
    check("start_resetPintar", oResetPintar, 1);
    check("start_lfsr", oEnableLFSR, 1);
    @(negedge iClk);
    check("cuenta2_resetPintar", oResetPintar, 0);
    check("cuenta2_estado", oEstado, 1);
    iStart = 1'b0;
    for (int i = 1; i <= 180; i++) begin
      tick(1'b0, 1'b0);
      if (i == 59)  check("cuenta_t59", oCuenta, 3);
      if (i == 60)  check("cuenta_t60", oCuenta, 2);
      if (i == 179) check("estado_t179", oEstado, 1);
    end
    check("juego_estado", oEstado, 2);
    check("juego_cuenta", oCuenta, 0);

    // 2. level 0: obstacle every 30 ticks, player every tick
    for (int i = 1; i <= 90; i++) tick((i % 30) == 0, 1'b1);

    // 4. pause: counter survives the pause
    for (int i = 1; i <= 10; i++) tick(1'b0, 1'b1);
    @(negedge iClk);
    iPause = 1'b1;
    @(negedge iClk);
`ifdef SEQ_PAUSA_EN
    check("pausa_estado", oEstado, 3);
    check("pausa_pintar", oPintar, 1);
    @(negedge iClk);
    iPause = 1'b0;
    for (int i = 1; i <= 50; i++) tick(1'b0, 1'b0);
    @(negedge iClk);
    iStop  = 1'b1;
    iStart = 1'b1;
    @(negedge iClk);
    check("pausa_ignora", oEstado, 3);
    iStop  = 1'b0;
    iStart = 1'b0;
    @(negedge iClk);
    iPause = 1'b1;
    @(negedge iClk);
    check("reanuda_estado", oEstado, 2);
`else
    check("sin_pausa_estado", oEstado, 2);
    @(negedge iClk);
`endif
    iPause = 1'b0;
    for (int i = 1; i <= 20; i++) tick(i == 20, 1'b1);

    // 3. levels and period clamp
    repeat (5) punto();
    check("nivel_1", oNivel, 1);
    for (int i = 1; i <= 26; i++) tick(i == 26, 1'b1);
    for (int i = 1; i <= 10; i++) tick(1'b0, 1'b1);
    repeat (35) punto();
    check("nivel_sat", oNivel, 7);
    tick(1'b1, 1'b1);
    for (int i = 1; i <= 12; i++) tick((i % 6) == 0, 1'b1);

    // 5. crash wins over pause and tick in the same cycle
    @(negedge iClk);
    iStop      = 1'b1;
    iPause     = 1'b1;
    iFrameTick = 1'b1;
    iPunto     = 1'b1;
    pushExp(1'b0, 1'b0);
    @(negedge iClk);
    iFrameTick = 1'b0;
    iPunto     = 1'b0;
    check("choque_estado", oEstado, 4);
    check("choque_lfsr", oEnableLFSR, 0);
    check("choque_pintar0", oPintar, 1);
    @(negedge iClk);
    iStop  = 1'b0;
    iPause = 1'b0;
    for (int k = 1; k <= 90; k++) begin
      tick(1'b0, 1'b0);
      if (k == 7)  check("blink_7", oPintar, 1);
      if (k == 8)  check("blink_8", oPintar, 0);
      if (k == 15) check("blink_15", oPintar, 0);
      if (k == 16) check("blink_16", oPintar, 1);
      if (k == 89) check("choque_t89", oEstado, 4);
    end
    check("fin_estado", oEstado, 5);
    check("fin_pintar", oPintar, 1);
    check("fin_nivel", oNivel, 7);

    // 6. restart from FIN, then reset mid-game
    @(negedge iClk);
    iStart = 1'b1;
    @(negedge iClk);
    check("restart_estado", oEstado, 1);
    check("restart_nivel", oNivel, 0);
    check("restart_cuenta", oCuenta, 3);
    check("restart_resetPintar", oResetPintar, 1);
    iStart = 1'b0;
    @(negedge iClk);
    check("restart_resetPintar_1cyc", oResetPintar, 0);
    for (int i = 1; i <= 180; i++) tick(1'b0, 1'b0);
    check("juego2_estado", oEstado, 2);
    repeat (4) punto();
    check("puntos_limpios", oNivel, 0);
    punto();
    check("nivel_tras_5", oNivel, 1);
    for (int i = 1; i <= 3; i++) tick(1'b0, 1'b1);
    @(negedge iClk);
    iReset     = 1'b0;
    iFrameTick = 1'b1;
    pushExp(1'b0, 1'b0);
    @(negedge iClk);
    iFrameTick = 1'b0;
    iReset     = 1'b1;
    check("rst2_estado", oEstado, 0);
    check("rst2_resetPintar", oResetPintar, 1);
    check("rst2_nivel", oNivel, 0);
    check("rst2_pintar", oPintar, 0);

    repeat (3) @(negedge iClk);
    while (q.size() > 0) begin
      expT e;
      e = q.pop_front();
      nCmp++;
      nBad++;
      $display("FAIL step_leftover: expectation for cycle %0d got no check, expected one", e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
